// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions and the hex font.
// Patterns are active-high; pin polarity is applied by the scan controller.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam int SEG_W  = 8;

  localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_font_rom.sv
// Hex nibble to active-high g..a pattern; purely combinational, no handshake.
module seg_font_rom
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = seg_font(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: one slot per digit, dead-time guard, frame-aligned updates.
// an/segment registered one cycle behind the scan state; optional SEG_LZ_SUPPRESS_EN blanks leading zeros.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 200000,
  parameter int DEAD_CYCLES = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        segment,
  output logic                    frame_done
);

  localparam int   PW  = $clog2(CLK_DIV);
  localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   VW  = 4 * NUM_DIGITS;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic                  slot_end;
  logic                  frame_end;

  logic [VW-1:0]         pend_value;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_vld;
  logic [VW-1:0]         disp_value;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] disp_blank;

  logic                  dead;
  logic [NUM_DIGITS-1:0] eff_blank;
  logic [NUM_DIGITS-1:0] an_hot;
  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  cur_blk;
  logic [6:0]            font_pat;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [SEG_W-1:0]      seg_nxt;

  assign slot_end  = (presc == PW'(CLK_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      presc      <= slot_end ? '0 : presc + 1'b1;
      frame_done <= frame_end;
      if (slot_end)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses pending so it is shown immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (frame_end && load) begin
      disp_value <= value;
      disp_dp    <= dp;
      disp_blank <= blank;
      pend_vld   <= 1'b0;
    end else begin
      if (frame_end && pend_vld) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        pend_vld   <= 1'b0;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_vld   <= 1'b1;
      end
    end
  end

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign dead = 1'b0;
    end else begin : g_dead
      assign dead = (presc < PW'(DEAD_CYCLES));
    end
  endgenerate

`ifdef SEG_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  upper_zero;

  // Walk down from the leftmost digit; digit 0 is never a candidate.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (disp_value[i*4 +: 4] == 4'h0);
      lz_blank[i] = upper_zero && !disp_dp[i];
    end
  end

  assign eff_blank = disp_blank | lz_blank;
`else
  assign eff_blank = disp_blank;
`endif

  always_comb begin
    an_hot  = '0;
    nib     = 4'h0;
    cur_dp  = 1'b0;
    cur_blk = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_hot[i] = (idx == IW'(i));
      if (idx == IW'(i)) begin
        nib     = disp_value[i*4 +: 4];
        cur_dp  = disp_dp[i];
        cur_blk = eff_blank[i];
      end
    end
  end

  seg_font_rom u_font (
    .nibble  (nib),
    .pattern (font_pat)
  );

  always_comb begin
    an_nxt  = '0;
    seg_nxt = SEG_OFF;
    if (!dead && !cur_blk) begin
      an_nxt                = an_hot;
      seg_nxt[SEG_DP]       = cur_dp;
      seg_nxt[SEG_G:SEG_A]  = font_pat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an      <= {NUM_DIGITS{POL}};
      segment <= {SEG_W{POL}};
    end else begin
      an      <= an_nxt ^ {NUM_DIGITS{POL}};
      segment <= seg_nxt ^ {SEG_W{POL}};
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at CLK_DIV=8, DEAD_CYCLES=2, four digits, active-high pins.
// cyc counts rising edges since the last reset release; outputs are sampled 1 time unit after each edge.
module tb_seg_scan_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  value;
  logic [N-1:0] dp;
  logic [N-1:0] blank;
  logic         load;
  logic [N-1:0] an;
  logic [7:0]   segment;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int on_cnt [N];
  int fd_cnt;
  int dp_cnt;
  int dp_stray;

  seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (8),
    .DEAD_CYCLES (2),
    .ACTIVE_LOW  (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .load       (load),
    .an         (an),
    .segment    (segment),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs are held for exactly the edge numbered 'at'.
  task automatic do_load(input int at, input logic [15:0] v, input logic [N-1:0] d,
                         input logic [N-1:0] b);
    run_to(at - 1);
    value = v;
    dp    = d;
    blank = b;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic count_frame();
    for (int j = 0; j < N; j++) on_cnt[j] = 0;
    fd_cnt   = 0;
    dp_cnt   = 0;
    dp_stray = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      for (int j = 0; j < N; j++) on_cnt[j] += int'(an[j]);
      fd_cnt   += int'(frame_done);
      dp_cnt   += int'(segment[7]);
      dp_stray += int'(segment[7] & ~an[0]);
    end
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    dp    = '0;
    blank = '0;
    #12;
    check("rst_an", 32'(an), 32'h0);
    check("rst_seg", 32'(segment), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);

    // Basic scan of 12AF; display stays 0 until the first boundary at edge 32.
    release_rst();
    do_load(1, 16'h12AF, 4'b0000, 4'b0000);
    check("dead0_an", 32'(an), 32'h0);
    run_to(2);
    check("dead1_an", 32'(an), 32'h0);
    run_to(3);
    check("first_an", 32'(an), 32'h1);
    check("first_seg_zero", 32'(segment), 32'h3F);
    run_to(32);
    check("fd_pulse", 32'(frame_done), 32'h1);
    run_to(33);
    check("fd_width", 32'(frame_done), 32'h0);
    check("bnd_dead_an", 32'(an), 32'h0);
    run_to(35);
    check("d0_an", 32'(an), 32'h1);
    check("d0_F", 32'(segment), 32'h71);
    run_to(43);
    check("d1_an", 32'(an), 32'h2);
    check("d1_A", 32'(segment), 32'h77);
    run_to(51);
    check("d2_an", 32'(an), 32'h4);
    check("d2_2", 32'(segment), 32'h5B);
    run_to(59);
    check("d3_an", 32'(an), 32'h8);
    check("d3_1", 32'(segment), 32'h06);
    run_to(64);
    count_frame();
    for (int j = 0; j < N; j++) check($sformatf("duty_an%0d", j), 32'(on_cnt[j]), 32'd6);
    check("fd_per_frame", 32'(fd_cnt), 32'd1);

    // Last load wins; nothing changes before the boundary at 128.
    do_load(102, 16'h1111, 4'b0000, 4'b0000);
    run_to(107);
    check("pre_bnd_d1", 32'(segment), 32'h77);
    do_load(112, 16'h2222, 4'b0000, 4'b0000);
    run_to(131);
    check("lastwin_d0", 32'(segment), 32'h5B);
    run_to(139);
    check("lastwin_d1", 32'(segment), 32'h5B);

    // Load on the boundary edge 160 while 3333 is pending.
    do_load(140, 16'h3333, 4'b0000, 4'b0000);
    do_load(160, 16'h5555, 4'b0000, 4'b0000);
    run_to(163);
    check("coinc_an", 32'(an), 32'h1);
    check("coinc_seg", 32'(segment), 32'h6D);
    run_to(195);
    check("coinc_no_second", 32'(segment), 32'h6D);

    // Blank digit 2, decimal point on digit 0.
    do_load(200, 16'h8888, 4'b0001, 4'b0100);
    run_to(224);
    count_frame();
    check("blank_an2_cnt", 32'(on_cnt[2]), 32'd0);
    check("blank_an0_cnt", 32'(on_cnt[0]), 32'd6);
    check("dp_cnt", 32'(dp_cnt), 32'd6);
    check("dp_stray", 32'(dp_stray), 32'd0);
    run_to(259);
    check("dp_d0_seg", 32'(segment), 32'hFF);
    run_to(275);
    check("blank_d2_an", 32'(an), 32'h0);
    check("blank_d2_seg", 32'(segment), 32'h0);

    // Asynchronous reset mid-slot on digit 2 with a load still pending.
    do_load(280, 16'h4321, 4'b0000, 4'b0000);
    do_load(300, 16'h7777, 4'b0000, 4'b0000);
    run_to(307);
    check("pre_rst_an", 32'(an), 32'h4);
    check("pre_rst_seg", 32'(segment), 32'h4F);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'h0);
    check("async_rst_seg", 32'(segment), 32'h0);
    @(posedge clk);
    release_rst();
    run_to(1);
    check("rst2_dead0", 32'(an), 32'h0);
    run_to(2);
    check("rst2_dead1", 32'(an), 32'h0);
    run_to(3);
    check("rst2_d0_an", 32'(an), 32'h1);
    check("rst2_d0_seg", 32'(segment), 32'h3F);
    run_to(35);
    check("discard_d0", 32'(segment), 32'h3F);
    run_to(43);
    check("discard_d1_an", 32'(an), 32'h2);
    check("discard_d1", 32'(segment), 32'h3F);

    // Leading zeros: 0040.
    do_load(50, 16'h0040, 4'b0000, 4'b0000);
    run_to(64);
    count_frame();
`ifdef SEG_LZ_SUPPRESS_EN
    check("lz_an3_cnt", 32'(on_cnt[3]), 32'd0);
    check("lz_an2_cnt", 32'(on_cnt[2]), 32'd0);
`else
    check("lz_an3_cnt", 32'(on_cnt[3]), 32'd6);
    check("lz_an2_cnt", 32'(on_cnt[2]), 32'd6);
`endif
    check("lz_fd_cnt", 32'(fd_cnt), 32'd1);
    run_to(99);
    check("lz_d0_an", 32'(an), 32'h1);
    check("lz_d0_seg", 32'(segment), 32'h3F);
    run_to(107);
    check("lz_d1_an", 32'(an), 32'h2);
    check("lz_d1_seg", 32'(segment), 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 200000, clk cycles per digit slot; legal range >= 4.
REQ-003 SHALL have parameter DEAD_CYCLES, default 2, anode-off guard cycles at the start of each slot; legal range 0..CLK_DIV-2.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; when 1, an and segment are inverted at the pins.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port value, input, 4*NUM_DIGITS, hex nibbles; value[3:0] is digit 0, the rightmost digit.
REQ-008 SHALL have port dp, input, NUM_DIGITS, decimal point per digit.
REQ-009 SHALL have port blank, input, NUM_DIGITS, forces the digit dark.
REQ-010 SHALL have port load, input, 1, single-cycle strobe that captures value/dp/blank.
REQ-011 SHALL have port an, output, NUM_DIGITS, registered anode enables.
REQ-012 SHALL have port segment, output, 8, registered; bit7 = dp, bits6..0 = g..a.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse when a full scan completes.

Function
REQ-014 Prescaler SHALL count 0..CLK_DIV-1 and wrap; slot_end = (prescaler == CLK_DIV-1).
REQ-015 Digit index SHALL advance on slot_end: 0,1,..,NUM_DIGITS-1, then 0; NUM_DIGITS=1 stays at 0.
REQ-016 Frame boundary SHALL be slot_end with index == NUM_DIGITS-1; frame_done SHALL assert the following cycle, for exactly 1 cycle.
REQ-017 load SHALL capture value/dp/blank into a pending register and set pending_valid; a later load before the boundary overwrites it (last load wins).
REQ-018 At the frame boundary the display register SHALL take the pending data if pending_valid, then clear pending_valid. Changes to the displayed data SHALL occur only at frame boundaries.
REQ-019 If load coincides with the frame boundary, the display register SHALL take the load-cycle inputs directly and pending_valid SHALL end cleared.
REQ-020 an SHALL be one-hot on the current index, except all-off while prescaler < DEAD_CYCLES or while the digit's blank bit is 1.
REQ-021 segment SHALL be the hex font for the current nibble, active-high before polarity: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; bit7 = dp of the current digit; 00 when blanked or in dead time.
REQ-022 an and segment SHALL be registered, lagging index/prescaler by exactly 1 cycle, and SHALL always change in the same cycle as each other.

Reset
REQ-023 rst SHALL clear, asynchronously: prescaler 0, index 0, display/pending registers 0, pending_valid 0, frame_done 0, an all-off, segment all-off (pin levels per ACTIVE_LOW).
REQ-024 rst asserted mid-scan SHALL discard any pending load; after release the scan SHALL restart at digit 0, beginning with dead time, showing "0" on all digits until the first boundary update.

Configuration
REQ-025 Macro SEG_LZ_SUPPRESS_EN defined: a digit whose nibble and all higher nibbles are 0, and whose dp is 0, SHALL be treated as blanked. Digit 0 SHALL never be suppressed.
REQ-026 Macro SEG_LZ_SUPPRESS_EN undefined: no leading-zero suppression, and no suppression logic SHALL be present.

Structure
REQ-027 The font table function and the segment bit-position constants SHALL reside in shared package seg_pkg.
REQ-028 Sub-module seg_font_rom (4-bit nibble to 7-bit active-high pattern, combinational) SHALL be instantiated once.

Verification (CLK_DIV=8, DEAD_CYCLES=2, NUM_DIGITS=4, ACTIVE_LOW=0)
REQ-029 Reset release, load value=16'h12AF -> from the second frame, digits show F,A,2,1; each an bit high for 6 of every 8 cycles; frame_done every 32 cycles.
REQ-030 Load 16'h1111 then load 16'h2222 within one frame -> no 1111 displayed; 2222 appears at the next boundary.
REQ-031 load coincident with boundary, value=16'h5555 -> 5555 shown in the very next slot; no second update at the following boundary.
REQ-032 blank=4'b0100, dp=4'b0001 -> an[2] never high; segment[7]=1 only during digit 0 slots.
REQ-033 rst pulsed mid-slot on digit 2 -> an=0 and segment=00 immediately (asynchronous); after release digit 0 is shown first, after 2 dead cycles.
REQ-034 With SEG_LZ_SUPPRESS_EN, value=16'h0040 -> an[3] never high, an[2] never high, digit 1 shows 66, digit 0 shows 3F.
